// File: rtl/imem_boot_loader.sv
// Packs a length-prefixed little-endian byte stream into 32-bit instruction-memory writes and holds the core in reset until a full image lands.
// Latency: a word is written the cycle after its 4th byte transfers; backpressure: rx_ready drops in IDLE, WRITE, DONE and ERROR.
module imem_boot_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(DEPTH);

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      buf_q, buf_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             xfer;
    logic [15:0]      len_full;
    logic [CNT_W-1:0] word_idx_nxt;

    // Every output is either a flop or a decode of the state flop.
    assign rx_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign imem_we    = (state_q == S_WRITE);
    assign busy       = rx_ready || imem_we;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERROR);
    assign core_reset = (state_q != S_DONE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    assign xfer         = rx_valid && rx_ready;
    assign len_full     = {rx_data, len_q[7:0]};
    assign word_idx_nxt = word_idx_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if ((len_full == 16'd0) || (len_full > MAX_LEN)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Latch the write beat now so WRITE presents it straight from flops.
                        wdata_d = {rx_data, buf_q};
                        addr_d  = {{(30-CNT_W){1'b0}}, word_idx_q, 2'b00};
                        state_d = S_WRITE;
                    end else begin
                        buf_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_nxt;
                if (16'(word_idx_nxt) == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised bench for imem_boot_loader: images are expanded into an expected write list and compared against observed imem writes.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;

    imem_boot_loader #(.DEPTH(64), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          we_seen   = 0;
    int          we_expect = 0;
    logic [31:0] img[0:127];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every write must match the head of the expected list and occur with rx_ready low.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_seen++;
            chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                chk("write_addr", imem_addr, exp_addr_q.pop_front());
                chk("write_data", imem_wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte after a random idle gap; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noise);
        int guard;
        int gap;
        gap = $urandom_range(gap_max, 0);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = noise ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = noise ? 1'($urandom) : 1'b0;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            start = noise ? 1'($urandom) : 1'b0;
            guard++;
        end
        if (guard >= 200) begin
            chk("rx_ready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max, input bit noise);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap_max, noise);
        end
    endtask

    // Loads img[0:len-1] (or just the header when len is illegal) and checks the end state.
    task automatic run_image(input int len, input int gap_max, input bit noise);
        bit legal;
        legal = (len != 0) && (len <= 64);
        if (legal) begin
            for (int i = 0; i < len; i++) begin
                exp_addr_q.push_back(32'(i * 4));
                exp_data_q.push_back(img[i]);
            end
            we_expect += len;
        end
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("core_reset_after_start", 32'(core_reset), 32'd1);
        chk("flags_after_start", {30'd0, done, err}, 32'd0);
        send_byte(8'(len), gap_max, noise);
        send_byte(8'(len >> 8), gap_max, noise);
        if (!legal) begin
            @(negedge clk);
            chk("err_set", 32'(err), 32'd1);
            chk("err_core_reset", 32'(core_reset), 32'd1);
            chk("err_not_busy", {30'd0, busy, done}, 32'd0);
        end else begin
            for (int i = 0; i < len; i++) begin
                send_word(img[i], gap_max, noise);
            end
            @(negedge clk);
            chk("last_write_cycle", 32'(imem_we), 32'd1);
            @(negedge clk);
            chk("done_set", 32'(done), 32'd1);
            chk("done_core_reset", 32'(core_reset), 32'd0);
            chk("done_not_busy", {30'd0, busy, err}, 32'd0);
            chk("done_addr_held", imem_addr, 32'((len - 1) * 4));
            chk("done_data_held", imem_wdata, img[len-1]);
            chk("exp_left", 32'(exp_addr_q.size()), 32'd0);
        end
        chk("write_count", 32'(we_seen), 32'(we_expect));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);

        // Two-word image, back-to-back bytes, then with random gaps.
        img[0] = 32'h0010_0513;
        img[1] = 32'h0020_0593;
        run_image(2, 0, 1'b0);
        run_image(2, 5, 1'b0);

        // Illegal lengths, then a legal reload.
        run_image(0, 3, 1'b0);
        run_image(65, 3, 1'b0);
        run_image(2, 2, 1'b0);

        // Full-depth image with data equal to the word index.
        for (int i = 0; i < 64; i++) img[i] = 32'(i);
        run_image(64, 0, 1'b0);

        // Reset in the middle of the second word.
        img[0] = $urandom;
        img[1] = $urandom;
        exp_addr_q.push_back(32'd0);
        exp_data_q.push_back(img[0]);
        we_expect += 1;
        pulse_start();
        send_byte(8'd2, 1, 1'b0);
        send_byte(8'd0, 1, 1'b0);
        send_word(img[0], 1, 1'b0);
        send_byte(img[1][7:0], 1, 1'b0);
        send_byte(img[1][15:8], 1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_imem_we", 32'(imem_we), 32'd0);
        chk("abort_core_reset", 32'(core_reset), 32'd1);
        chk("abort_idle", {29'd0, busy, done, err}, 32'd0);
        chk("abort_rx_ready", 32'(rx_ready), 32'd0);
        chk("abort_writes", 32'(we_seen), 32'(we_expect));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_image(3, 2, 1'b0);

        // Restart from DONE with start pulses thrown at the busy loader.
        chk("pre_restart_done", 32'(done), 32'd1);
        img[0] = $urandom;
        run_image(1, 4, 1'b1);

        // Random images.
        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(8, 1);
            for (int i = 0; i < len; i++) img[i] = $urandom;
            run_image(len, $urandom_range(4, 0), 1'(t & 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
